// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity modes,
// receiver states and the 2-of-3 vote used for every bit decision.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for the asynchronous rx line; resets to the idle
// (high) level so reset never looks like a start bit.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 5..9 data bits, optional parity, 1 or 2 stop bits,
// 3-sample majority voting, break/overrun reporting. States: IDLE START DATA PARITY STOP.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx,
    input  logic [1:0]           parity_mode,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 busy
);

    localparam int             TW          = $clog2(OVERSAMPLE);
    localparam int             M           = OVERSAMPLE / 2;
    localparam logic [TW-1:0]  T_LO        = TW'(M - 1);
    localparam logic [TW-1:0]  T_MID       = TW'(M);
    localparam logic [TW-1:0]  T_HI        = TW'(M + 1);
    localparam logic [TW-1:0]  T_LAST      = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]     B_LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]     B_LAST_STOP = 4'(STOP_BITS - 1);

    logic                 w_rx_s;
    logic                 w_vote;
    logic                 w_par_en;
    logic                 w_complete;
    logic                 w_stop0;
    logic                 w_frame_err;
    logic                 w_par_err;
    logic                 w_break;

    rx_state_t            r_state;
    logic [TW-1:0]        r_tick;
    logic [3:0]           r_bit;
    logic                 r_s0;
    logic                 r_s1;
    logic [DATA_BITS-1:0] r_shift;
    logic [1:0]           r_par_mode;
    logic                 r_par_bit;
    logic                 r_stop_err;
    logic                 r_stop0;
    logic                 r_rearm;
    logic                 r_busy;

    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_par_err;
    logic                 r_break;
    logic                 r_overrun;

    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (w_rx_s)
    );

    assign w_vote   = majority3(r_s0, r_s1, w_rx_s);
    assign w_par_en = (r_par_mode == PAR_EVEN) || (r_par_mode == PAR_ODD);

    assign w_complete  = baud_tick && (r_state == STOP) && (r_tick == T_HI)
                         && (r_bit == B_LAST_STOP);
    assign w_stop0     = (r_bit == 4'd0) ? w_vote : r_stop0;
    assign w_frame_err = r_stop_err | ~w_vote;
    assign w_par_err   = w_par_en && ((^r_shift ^ r_par_bit) != (r_par_mode == PAR_ODD));
    assign w_break     = (r_shift == '0) && (!w_par_en || !r_par_bit) && !w_stop0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_tick     <= '0;
            r_bit      <= '0;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_shift    <= '0;
            r_par_mode <= PAR_NONE;
            r_par_bit  <= 1'b0;
            r_stop_err <= 1'b0;
            r_stop0    <= 1'b1;
            r_rearm    <= 1'b1;
            r_busy     <= 1'b0;
        end else if (baud_tick) begin
            if (r_tick == T_LO) r_s0 <= w_rx_s;
            if (r_tick == T_MID) r_s1 <= w_rx_s;

            case (r_state)
                IDLE: begin
                    // After a break the line must be seen high once before a new start is accepted.
                    if (w_rx_s) begin
                        r_rearm <= 1'b1;
                    end else if (r_rearm) begin
                        r_state    <= START;
                        r_busy     <= 1'b1;
                        r_tick     <= '0;
                        r_bit      <= '0;
                        r_par_mode <= parity_mode;
                        r_stop_err <= 1'b0;
                    end
                end

                START: begin
                    r_tick <= r_tick + TW'(1);
                    if (r_tick == T_LAST) begin
                        r_tick  <= '0;
                        r_bit   <= '0;
                        r_state <= DATA;
                    end
                    if ((r_tick == T_HI) && w_vote) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_tick  <= '0;
                    end
                end

                DATA: begin
                    r_tick <= r_tick + TW'(1);
                    if (r_tick == T_HI) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                    if (r_tick == T_LAST) begin
                        r_tick <= '0;
                        if (r_bit == B_LAST_DATA) begin
                            r_bit   <= '0;
                            r_state <= w_par_en ? PARITY : STOP;
                        end else begin
                            r_bit <= r_bit + 4'd1;
                        end
                    end
                end

                PARITY: begin
                    r_tick <= r_tick + TW'(1);
                    if (r_tick == T_HI) r_par_bit <= w_vote;
                    if (r_tick == T_LAST) begin
                        r_tick  <= '0;
                        r_bit   <= '0;
                        r_state <= STOP;
                    end
                end

                STOP: begin
                    r_tick <= r_tick + TW'(1);
                    if (r_tick == T_LAST) begin
                        r_tick <= '0;
                        r_bit  <= r_bit + 4'd1;
                    end
                    if (r_tick == T_HI) begin
                        if (!w_vote) r_stop_err <= 1'b1;
                        if (r_bit == 4'd0) r_stop0 <= w_vote;
                        // Final stop bit ends at its sample point so back-to-back frames are caught.
                        if (r_bit == B_LAST_STOP) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_tick  <= '0;
                            r_bit   <= '0;
                            if (w_break) r_rearm <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_tick  <= '0;
                    r_bit   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_par_err   <= 1'b0;
            r_break     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_complete) begin
                if (!r_valid || rx_ready) begin
                    r_data      <= r_shift;
                    r_frame_err <= w_frame_err;
                    r_par_err   <= w_par_err;
                    r_break     <= w_break;
                    r_valid     <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data    = r_data;
    assign rx_valid   = r_valid;
    assign frame_err  = r_frame_err;
    assign parity_err = r_par_err;
    assign break_det  = r_break;
    assign overrun    = r_overrun;
    assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance for most scenarios and a
// 9-bit / 2-stop instance for the mid-frame reset scenario.
module tb_uart_rx_param;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       rst8, rst9;
    logic       baud_tick = 1'b0;
    logic       rx8, rx9, ready8, ready9;
    logic [1:0] parity_mode;

    logic [7:0] rx_data8;
    logic [8:0] rx_data9;
    logic       v8, fe8, pe8, bd8, ovr8, busy8;
    logic       v9, fe9, pe9, bd9, ovr9, busy9;

    int n_tests = 0;
    int n_fail  = 0;
    int bcnt    = 0;

    int         hs8 = 0, ovr_n8 = 0, hs9 = 0;
    logic [7:0] cap_d8 = '0;
    logic [8:0] cap_d9 = '0;
    logic       cap_fe8 = 0, cap_pe8 = 0, cap_bd8 = 0;
    logic       cap_fe9 = 0, cap_pe9 = 0, cap_bd9 = 0;

    uart_rx_param #(.DATA_BITS(8), .STOP_BITS(1), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .reset(rst8), .baud_tick(baud_tick), .rx(rx8), .parity_mode(parity_mode),
        .rx_data(rx_data8), .rx_valid(v8), .rx_ready(ready8), .frame_err(fe8),
        .parity_err(pe8), .break_det(bd8), .overrun(ovr8), .busy(busy8)
    );

    uart_rx_param #(.DATA_BITS(9), .STOP_BITS(2), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut9 (
        .clk(clk), .reset(rst9), .baud_tick(baud_tick), .rx(rx9), .parity_mode(parity_mode),
        .rx_data(rx_data9), .rx_valid(v9), .rx_ready(ready9), .frame_err(fe9),
        .parity_err(pe9), .break_det(bd9), .overrun(ovr9), .busy(busy9)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        bcnt      = (bcnt == 3) ? 0 : bcnt + 1;
        baud_tick = (bcnt == 0);
    end

    // Handshakes and overrun pulses as seen by the consumer at each clock edge.
    always @(posedge clk) begin
        if (v8 && ready8) begin
            hs8     <= hs8 + 1;
            cap_d8  <= rx_data8;
            cap_fe8 <= fe8;
            cap_pe8 <= pe8;
            cap_bd8 <= bd8;
        end
        if (ovr8) ovr_n8 <= ovr_n8 + 1;
        if (v9 && ready9) begin
            hs9     <= hs9 + 1;
            cap_d9  <= rx_data9;
            cap_fe9 <= fe9;
            cap_pe9 <= pe9;
            cap_bd9 <= bd9;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit which9, input logic v);
        if (which9) rx9 = v;
        else        rx8 = v;
        wait_clk(BIT_CLK);
    endtask

    task automatic send_frame(input bit which9, input logic [8:0] d, input int nbits,
                              input bit has_par, input logic pbit, input int nstop,
                              input logic stopv);
        drive(which9, 1'b0);
        for (int i = 0; i < nbits; i++) drive(which9, d[i]);
        if (has_par) drive(which9, pbit);
        for (int i = 0; i < nstop; i++) drive(which9, stopv);
        if (which9) rx9 = 1'b1;
        else        rx8 = 1'b1;
    endtask

    task automatic test_reset;
        n_tests++;
        if (v8 !== 1'b0 || ovr8 !== 1'b0 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl8: got valid=%b ovr=%b busy=%b expected 0 0 0", v8, ovr8, busy8);
        end
        n_tests++;
        if (rx_data8 !== 8'h00 || fe8 !== 1'b0 || pe8 !== 1'b0 || bd8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data8: got data=%h fe=%b pe=%b bd=%b expected 00 0 0 0", rx_data8, fe8, pe8, bd8);
        end
        n_tests++;
        if (v9 !== 1'b0 || busy9 !== 1'b0 || rx_data9 !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_dut9: got valid=%b busy=%b data=%h expected 0 0 000", v9, busy9, rx_data9);
        end
    endtask

    task automatic test_basic_8n1;
        int h;
        h = hs8;
        send_frame(1'b0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
        wait_clk(20);
        n_tests++;
        if (hs8 !== h + 1) begin
            n_fail++;
            $display("FAIL basic_count: got %0d frames expected 1", hs8 - h);
        end
        n_tests++;
        if (cap_d8 !== 8'hA5) begin
            n_fail++;
            $display("FAIL basic_data: got %h expected a5", cap_d8);
        end
        n_tests++;
        if (cap_fe8 !== 1'b0 || cap_pe8 !== 1'b0 || cap_bd8 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_flags: got fe=%b pe=%b bd=%b expected 0 0 0", cap_fe8, cap_pe8, cap_bd8);
        end
        n_tests++;
        if (v8 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_valid_clear: got %b expected 0", v8);
        end
    endtask

    task automatic test_parity;
        parity_mode = 2'b01;
        send_frame(1'b0, 9'h003, 8, 1'b1, 1'b1, 1, 1'b1);
        wait_clk(20);
        n_tests++;
        if (cap_d8 !== 8'h03 || cap_pe8 !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_bad: got data=%h pe=%b expected 03 1", cap_d8, cap_pe8);
        end
        send_frame(1'b0, 9'h003, 8, 1'b1, 1'b0, 1, 1'b1);
        wait_clk(20);
        n_tests++;
        if (cap_d8 !== 8'h03 || cap_pe8 !== 1'b0 || cap_fe8 !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_good: got data=%h pe=%b fe=%b expected 03 0 0", cap_d8, cap_pe8, cap_fe8);
        end
        // Odd mode: 0x07 has three ones, so parity bit 0 makes the total odd.
        parity_mode = 2'b10;
        send_frame(1'b0, 9'h007, 8, 1'b1, 1'b0, 1, 1'b1);
        wait_clk(20);
        n_tests++;
        if (cap_d8 !== 8'h07 || cap_pe8 !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_odd: got data=%h pe=%b expected 07 0", cap_d8, cap_pe8);
        end
        parity_mode = 2'b00;
    endtask

    task automatic test_false_start_and_frame_err;
        int h;
        h = hs8;
        rx8 = 1'b0;
        wait_clk(12);
        n_tests++;
        if (busy8 !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_busy_high: got %b expected 1", busy8);
        end
        wait_clk(4);
        rx8 = 1'b1;
        wait_clk(150);
        n_tests++;
        if (busy8 !== 1'b0 || hs8 !== h) begin
            n_fail++;
            $display("FAIL glitch_ignored: got busy=%b frames=%0d expected 0 0", busy8, hs8 - h);
        end
        send_frame(1'b0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b0);
        wait_clk(200);
        n_tests++;
        if (hs8 !== h + 1 || cap_d8 !== 8'h5A) begin
            n_fail++;
            $display("FAIL ferr_data: got frames=%0d data=%h expected 1 5a", hs8 - h, cap_d8);
        end
        n_tests++;
        if (cap_fe8 !== 1'b1 || cap_bd8 !== 1'b0) begin
            n_fail++;
            $display("FAIL ferr_flags: got fe=%b bd=%b expected 1 0", cap_fe8, cap_bd8);
        end
    endtask

    task automatic test_break;
        int h;
        h = hs8;
        rx8 = 1'b0;
        wait_clk(15 * BIT_CLK);
        n_tests++;
        if (busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL break_no_rearm: got busy=%b expected 0", busy8);
        end
        wait_clk(5 * BIT_CLK);
        rx8 = 1'b1;
        wait_clk(200);
        n_tests++;
        if (hs8 !== h + 1) begin
            n_fail++;
            $display("FAIL break_count: got %0d frames expected 1", hs8 - h);
        end
        n_tests++;
        if (cap_d8 !== 8'h00 || cap_bd8 !== 1'b1 || cap_fe8 !== 1'b1 || cap_pe8 !== 1'b0) begin
            n_fail++;
            $display("FAIL break_flags: got data=%h bd=%b fe=%b pe=%b expected 00 1 1 0", cap_d8, cap_bd8, cap_fe8, cap_pe8);
        end
        send_frame(1'b0, 9'h07E, 8, 1'b0, 1'b0, 1, 1'b1);
        wait_clk(20);
        n_tests++;
        if (hs8 !== h + 2 || cap_d8 !== 8'h7E || cap_bd8 !== 1'b0 || cap_fe8 !== 1'b0) begin
            n_fail++;
            $display("FAIL after_break: got frames=%0d data=%h bd=%b fe=%b expected 2 7e 0 0", hs8 - h, cap_d8, cap_bd8, cap_fe8);
        end
    endtask

    task automatic test_back_to_back_overrun;
        int h;
        int o;
        h = hs8;
        o = ovr_n8;
        ready8 = 1'b0;
        send_frame(1'b0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1);
        send_frame(1'b0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1);
        wait_clk(20);
        n_tests++;
        if (v8 !== 1'b1 || rx_data8 !== 8'h11) begin
            n_fail++;
            $display("FAIL ovr_hold: got valid=%b data=%h expected 1 11", v8, rx_data8);
        end
        n_tests++;
        if (ovr_n8 - o !== 1 || hs8 !== h) begin
            n_fail++;
            $display("FAIL ovr_pulse: got pulses=%0d frames=%0d expected 1 0", ovr_n8 - o, hs8 - h);
        end
        ready8 = 1'b1;
        wait_clk(3);
        n_tests++;
        if (hs8 !== h + 1 || cap_d8 !== 8'h11) begin
            n_fail++;
            $display("FAIL ovr_handshake: got frames=%0d data=%h expected 1 11", hs8 - h, cap_d8);
        end
        n_tests++;
        if (v8 !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_valid_clear: got %b expected 0", v8);
        end
    endtask

    task automatic test_reset_mid_frame;
        int h;
        logic [8:0] partial;
        partial = 9'h155;
        h = hs9;
        drive(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, partial[i]);
        rx9 = partial[4];
        wait_clk(BIT_CLK / 2);
        n_tests++;
        if (busy9 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: got %b expected 1", busy9);
        end
        rst9 = 1'b1;
        wait_clk(2);
        n_tests++;
        if (busy9 !== 1'b0 || v9 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_state: got busy=%b valid=%b expected 0 0", busy9, v9);
        end
        rx9 = 1'b1;
        wait_clk(1);
        rst9 = 1'b0;
        wait_clk(100);
        n_tests++;
        if (hs9 !== h) begin
            n_fail++;
            $display("FAIL mid_no_partial: got %0d frames expected 0", hs9 - h);
        end
        send_frame(1'b1, 9'h1F3, 9, 1'b0, 1'b0, 2, 1'b1);
        wait_clk(20);
        n_tests++;
        if (cap_d9 !== 9'h1F3 || cap_fe9 !== 1'b0 || cap_pe9 !== 1'b0 || cap_bd9 !== 1'b0) begin
            n_fail++;
            $display("FAIL nine_bit_data: got data=%h fe=%b pe=%b bd=%b expected 1f3 0 0 0", cap_d9, cap_fe9, cap_pe9, cap_bd9);
        end
        wait_clk(200);
        n_tests++;
        if (hs9 !== h + 1) begin
            n_fail++;
            $display("FAIL nine_bit_once: got %0d frames expected 1", hs9 - h);
        end
    endtask

    initial begin
        rst8        = 1'b1;
        rst9        = 1'b1;
        rx8         = 1'b1;
        rx9         = 1'b1;
        ready8      = 1'b1;
        ready9      = 1'b1;
        parity_mode = 2'b00;
        wait_clk(5);
        test_reset();
        rst8 = 1'b0;
        rst9 = 1'b0;
        wait_clk(10);
        test_reset();
        test_basic_8n1();
        test_parity();
        test_false_start_and_frame_err();
        test_break();
        test_back_to_back_overrun();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver. Supports 5–9 data bits, runtime-selectable parity, and 1 or 2 stop bits. Uses 3-sample majority voting and reports framing, parity, break and overrun errors. Driven by the shared oversampling `baud_tick` from the baud generator; delivers frames on a valid/ready handshake toward a FIFO or host logic.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
- STOP_BITS, 1, stop bits checked per frame; legal values 1 or 2.
- OVERSAMPLE, 16, baud_tick pulses per bit; even, range 8..32.
- SYNC_STAGES, 2, flops in the `rx` input synchroniser; minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- baud_tick  in  1  one-clk pulse at OVERSAMPLE × baud rate.
- rx  in  1  asynchronous serial input; idles high.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 none.
- rx_data  out  DATA_BITS  received word.
- rx_valid  out  1  rx_data and the error flags are valid.
- rx_ready  in  1  consumer accepts the word when rx_valid && rx_ready.
- frame_err  out  1  stop bit sampled 0; qualified by rx_valid.
- parity_err  out  1  parity mismatch; qualified by rx_valid.
- break_det  out  1  break condition; qualified by rx_valid.
- overrun  out  1  one-clk pulse when a completed frame is dropped.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; all counters = 0; synchroniser flops = 1.
  - rx_data = 0; rx_valid, frame_err, parity_err, break_det, overrun, busy all = 0.
- All receive logic uses the synchronised rx (rx_s). Counters advance only on cycles where baud_tick = 1.
- Let M = OVERSAMPLE/2. Within each bit, tick_cnt runs 0..OVERSAMPLE-1. rx_s is sampled at tick_cnt = M-1, M and M+1; the bit value is the 2-of-3 majority.
- State machine: IDLE → START → DATA → PARITY (only if parity is enabled) → STOP → IDLE.
- IDLE:
  - On baud_tick with rx_s = 0: enter START with tick_cnt = 0.
  - On the same edge, latch parity_mode into a frame-local register. parity_mode changes mid-frame have no effect.
- START:
  - At tick M+1, a vote of 1 is a false start: return to IDLE and report nothing.
  - Otherwise, at tick OVERSAMPLE-1 go to DATA with bit_cnt = 0.
- DATA:
  - Store the vote into shift position bit_cnt.
  - After bit DATA_BITS-1 completes, go to PARITY if parity is enabled, else STOP.
- PARITY: compute parity_err = (XOR of data bits XOR the parity vote) != (odd ? 1 : 0).
- STOP:
  - Check STOP_BITS bits; any vote of 0 sets frame_err.
  - Non-final stop bits run the full OVERSAMPLE ticks.
  - The final stop bit ends at tick M+1, with no wait to the bit end, so back-to-back frames with 1 stop bit are received.
  - Then return to IDLE.
- break_det = 1 when all data bits, the parity bit (if present) and the first stop bit are all 0. frame_err is also 1 in that case.
- Frame completion (the clk after the final stop sample's baud_tick):
  - If rx_valid = 0, or rx_valid && rx_ready on that cycle: load rx_data and the three flags, and set rx_valid = 1.
  - Else: keep the old word, drop the new one, and pulse overrun for one clk.
- rx_valid clears on the clk after a handshake with no new completion. rx_data is stable while rx_valid && !rx_ready.
- If reset asserts mid-frame, everything returns to reset values immediately. No partial frame is ever reported.
- Continuous low after a break: the FSM re-enters START only after rx_s has been sampled high in IDLE once (rearm flag). Prevents a flood of break frames.

Decomposition:
- Package uart_pkg holds:
  - Parity-mode constants: PAR_NONE, PAR_EVEN, PAR_ODD.
  - The receiver state enum/localparams: IDLE, START, DATA, PARITY, STOP.
  - Shared helper function: majority3.
- One sub-module, uart_sync: SYNC_STAGES-deep bit synchroniser, reset to 1 asynchronously.

Test Plan:
1. 8N1, OVERSAMPLE 16, baud_tick every 4 clk, rx_ready = 1; send 0xA5 → one rx_valid with rx_data = 0xA5; all error flags 0.
2. parity_mode = 01 (even); send 0x03 with parity bit 1 → rx_data = 0x03, parity_err = 1. Resend with parity bit 0 → parity_err = 0.
3. Low pulse of 4 baud_ticks on idle rx → no rx_valid, busy returns to 0. Then send 0x5A with the stop bit driven 0 → frame_err = 1, break_det = 0.
4. Hold rx low for 2 frame times, then release → exactly one frame with rx_data = 0x00, break_det = 1, frame_err = 1. Next frame 0x7E is received cleanly.
5. rx_ready = 0; send 0x11 then 0x22 back-to-back → rx_data stays 0x11 and overrun pulses once. Raise rx_ready → handshake completes, then rx_valid = 0.
6. DATA_BITS = 9, STOP_BITS = 2; assert reset in the middle of data bit 4, release, then send 0x1F3 → rx_data = 0x1F3, valid exactly once; no stale partial frame.
